// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared types and helpers for the round-robin resource arbiter
package rr_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int MAX_N = 16;

    // One-hot vector with bit idx set; all zeros when idx falls outside 0..n-1.
    function automatic logic [MAX_N-1:0] onehot(input int idx, input int n);
        logic [MAX_N-1:0] v;
        v = '0;
        if (idx >= 0 && idx < n && idx < MAX_N) begin
            v[idx] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - round-robin pick: first request after the last winner, modulo N
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last,
    output logic           any,
    output logic [IDW-1:0] idx
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic           found;
    int             start;
    int             enc;
    int             sum;

    // Rotate req so bit 0 is last+1, priority-encode the lowest set bit, then rotate the index back.
    always_comb begin
        start = (int'(last) >= N - 1) ? 0 : int'(last) + 1;
        dbl   = {req, req};
        rot   = N'(dbl >> start);
        found = 1'b0;
        enc   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                enc   = k;
            end
        end
        sum = start + enc;
        if (sum >= N) begin
            sum = sum - N;
        end
        case (found)
            1'b1: begin
                any = 1'b1;
                idx = IDW'(sum);
            end
            default: begin
                any = 1'b0;
                idx = '0;
            end
        endcase
    end

endmodule

// File: rtl/rr_resource_arbiter.sv
// rtl/rr_resource_arbiter.sv - round-robin arbiter granting one requester a shared resource
module rr_resource_arbiter
    import rr_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic                 done,
    output logic [N-1:0]         gnt,
    output logic                 gnt_valid,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 timeout
);

    localparam int IDW = $clog2(N);
    localparam int HCW = $clog2(MAX_HOLD + 1);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);
    localparam logic [HCW-1:0] HOLD_SAT  = HCW'(MAX_HOLD);

    state_t         state, state_n;
    logic [HCW-1:0] hold_cnt, hold_n;
    logic [IDW-1:0] last, last_n;
    logic [N-1:0]   gnt_n;
    logic           gnt_valid_n;
    logic [IDW-1:0] gnt_id_n;
    logic           timeout_n;

    logic           pick_any;
    logic [IDW-1:0] pick_idx;
    logic           owner_req;
    logic           hold_expired;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req  (req),
        .last (last),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    assign owner_req    = req[gnt_id];
    assign hold_expired = (hold_cnt == HOLD_LAST);

    // State, counter, pointer and output flops; every output is registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            last      <= IDW'(N - 1);
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_n;
            hold_cnt  <= hold_n;
            last      <= last_n;
            gnt       <= gnt_n;
            gnt_valid <= gnt_valid_n;
            gnt_id    <= gnt_id_n;
            timeout   <= timeout_n;
        end
    end

    // Next-state: grant on any request when idle; release on done, withdrawal or hold expiry.
    always_comb begin
        state_n     = state;
        hold_n      = hold_cnt;
        last_n      = last;
        gnt_n       = gnt;
        gnt_valid_n = gnt_valid;
        gnt_id_n    = gnt_id;
        timeout_n   = 1'b0;
        case (state)
            IDLE: begin
                gnt_n       = '0;
                gnt_valid_n = 1'b0;
                gnt_id_n    = '0;
                hold_n      = '0;
                if (pick_any) begin
                    state_n     = BUSY;
                    gnt_n       = N'(onehot(int'(pick_idx), N));
                    gnt_valid_n = 1'b1;
                    gnt_id_n    = pick_idx;
                end
            end
            BUSY: begin
                if (done || !owner_req || hold_expired) begin
                    // Timeout only flags a forced release; done and withdrawal take precedence.
                    timeout_n   = !done && owner_req;
                    state_n     = IDLE;
                    last_n      = gnt_id;
                    hold_n      = '0;
                    gnt_n       = '0;
                    gnt_valid_n = 1'b0;
                    gnt_id_n    = '0;
                end else if (hold_cnt != HOLD_SAT) begin
                    hold_n = hold_cnt + 1'b1;
                end
            end
            default: begin
                state_n     = IDLE;
                gnt_n       = '0;
                gnt_valid_n = 1'b0;
                gnt_id_n    = '0;
                hold_n      = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_rr_resource_arbiter.sv
// tb/tb_rr_resource_arbiter.sv - scoreboard bench for the round-robin resource arbiter
module tb_rr_resource_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 15;

    typedef struct {
        logic [N-1:0] gnt;
        logic         valid;
        logic [1:0]   id;
        logic         timeout;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic         done = 1'b0;
    logic [N-1:0] gnt;
    logic         gnt_valid;
    logic [1:0]   gnt_id;
    logic         timeout;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t exp_q[$];

    // reference model state
    bit   m_busy = 0;
    int   m_last = N - 1;
    int   m_gid  = 0;
    int   m_age  = 0;

    rr_resource_arbiter #(
        .N        (N),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Model the edge: m_age counts cycles the current grant has been visible.
    function automatic exp_t model_edge(input logic r, input logic [N-1:0] rq, input logic d);
        exp_t e;
        bit   found;
        e = '{gnt: '0, valid: 1'b0, id: 2'd0, timeout: 1'b0};
        if (r) begin
            m_busy = 0;
            m_last = N - 1;
            m_gid  = 0;
            m_age  = 0;
        end else if (!m_busy) begin
            found = 0;
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (m_last + k) % N;
                if (!found && rq[i]) begin
                    found = 1;
                    m_gid = i;
                end
            end
            if (found) begin
                m_busy = 1;
                m_age  = 1;
            end
        end else if (d || !rq[m_gid] || m_age == MAX_HOLD) begin
            e.timeout = !d && rq[m_gid];
            m_last = m_gid;
            m_busy = 0;
        end else begin
            m_age++;
        end
        if (m_busy) begin
            e.gnt   = N'(1) << m_gid;
            e.valid = 1'b1;
            e.id    = 2'(m_gid);
        end
        return e;
    endfunction

    // Drive one cycle of inputs, push the expectation, then compare after the edge.
    task automatic step(input logic r, input logic [N-1:0] rq, input logic d);
        exp_t e;
        rst  = r;
        req  = rq;
        done = d;
        exp_q.push_back(model_edge(r, rq, d));
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_eq("sb_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_eq("sb_gnt", 32'(gnt), 32'(e.gnt));
            check_eq("sb_valid", 32'(gnt_valid), 32'(e.valid));
            check_eq("sb_id", 32'(gnt_id), 32'(e.id));
            check_eq("sb_timeout", 32'(timeout), 32'(e.timeout));
        end
        check_eq("inv_onehot", 32'($countones(gnt) <= 1), 32'd1);
        check_eq("inv_valid", 32'(gnt_valid), 32'(|gnt));
    endtask

    initial begin
        int order[5];
        int hold_len;
        int guard;
        logic [N-1:0] rq;
        logic d;

        // reset
        step(1, '0, 0);
        step(1, '0, 0);
        check_eq("rst_gnt", 32'(gnt), 32'd0);
        check_eq("rst_valid", 32'(gnt_valid), 32'd0);
        check_eq("rst_id", 32'(gnt_id), 32'd0);
        check_eq("rst_timeout", 32'(timeout), 32'd0);

        // 1: single request, done releases
        step(0, 4'b0000, 0);
        step(0, 4'b0001, 0);
        check_eq("t1_gnt", 32'(gnt), 32'h1);
        check_eq("t1_id", 32'(gnt_id), 32'd0);
        step(0, 4'b0001, 0);
        step(0, 4'b0001, 1);
        check_eq("t1_release", 32'(gnt), 32'd0);
        step(0, 4'b0000, 1);
        check_eq("t1_done_idle", 32'(gnt_valid), 32'd0);

        // 2: all requesting, done each grant
        step(1, '0, 0);
        for (int g = 0; g < 5; g++) begin
            step(0, 4'b1111, 0);
            order[g] = int'(gnt_id);
            check_eq("t2_valid", 32'(gnt_valid), 32'd1);
            step(0, 4'b1111, 1);
            check_eq("t2_idle_gap", 32'(gnt_valid), 32'd0);
        end
        check_eq("t2_order0", 32'(order[0]), 32'd0);
        check_eq("t2_order1", 32'(order[1]), 32'd1);
        check_eq("t2_order2", 32'(order[2]), 32'd2);
        check_eq("t2_order3", 32'(order[3]), 32'd3);
        check_eq("t2_order4", 32'(order[4]), 32'd0);
        step(0, 4'b0000, 0);

        // 3: hold timeout
        hold_len = 0;
        guard = 0;
        step(0, 4'b0100, 0);
        while (gnt == 4'b0100 && guard < 40) begin
            hold_len++;
            guard++;
            step(0, 4'b0100, 0);
        end
        check_eq("t3_hold_len", 32'(hold_len), 32'(MAX_HOLD));
        check_eq("t3_timeout", 32'(timeout), 32'd1);
        step(0, 4'b0100, 0);
        check_eq("t3_regrant", 32'(gnt_id), 32'd2);
        check_eq("t3_pulse_one", 32'(timeout), 32'd0);
        step(0, 4'b0000, 0);
        check_eq("t3_withdraw_no_to", 32'(timeout), 32'd0);
        step(0, 4'b0000, 0);

        // 4: withdrawal
        step(0, 4'b0010, 0);
        check_eq("t4_gnt1", 32'(gnt_id), 32'd1);
        step(0, 4'b0000, 0);
        check_eq("t4_drop", 32'(gnt), 32'd0);
        check_eq("t4_no_to", 32'(timeout), 32'd0);
        step(0, 4'b0011, 0);
        check_eq("t4_next0", 32'(gnt_id), 32'd0);
        step(0, 4'b0011, 1);
        step(0, 4'b0000, 0);

        // 5: done coincides with hold expiry
        step(0, 4'b0100, 0);
        for (int c = 0; c < MAX_HOLD - 1; c++) step(0, 4'b0100, 0);
        check_eq("t5_still_held", 32'(gnt), 32'h4);
        step(0, 4'b0100, 1);
        check_eq("t5_release", 32'(gnt), 32'd0);
        check_eq("t5_no_to", 32'(timeout), 32'd0);
        step(0, 4'b0000, 0);

        // 6: reset mid-grant
        step(0, 4'b0010, 0);
        step(0, 4'b0010, 0);
        step(1, 4'b0010, 0);
        check_eq("t6_rst_gnt", 32'(gnt), 32'd0);
        check_eq("t6_rst_valid", 32'(gnt_valid), 32'd0);
        check_eq("t6_rst_to", 32'(timeout), 32'd0);
        step(0, 4'b1000, 0);
        check_eq("t6_id3", 32'(gnt_id), 32'd3);
        step(0, 4'b1000, 1);
        step(0, 4'b1001, 0);
        check_eq("t6_wrap_id0", 32'(gnt_id), 32'd0);
        step(0, 4'b1001, 1);

        // random traffic against the model
        rq = 4'b0000;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
            d = ($urandom_range(0, 5) == 0);
            step(($urandom_range(0, 63) == 0), rq, d);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rr_resource_arbiter.md
Name: rr_resource_arbiter

Overview:
- Round-robin arbiter that shares one resource among N requesters. The resource is, for example, a shared result register written by a case-decoded update path.
- Grants exactly one requester at a time and holds the grant until the resource signals done, the requester withdraws, or a hold timeout expires.
- Sits between the requester front-ends and the shared datapath. It is the only driver of the datapath's select and enable.

Parameters:
- N, 4, number of requesters (2..16).
- MAX_HOLD, 15, maximum grant duration in cycles before forced release (1..255).
- IDW, $clog2(N), width of the grant index (derived; not overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N  per-requester request levels.
- done  input  1  resource completion pulse for the current grant.
- gnt  output  N  one-hot grant, registered.
- gnt_valid  output  1  high while any grant is active (OR of gnt), registered.
- gnt_id  output  IDW  index of the granted requester, registered; 0 when idle.
- timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Behaviour:
- Reset: one clock; reset is synchronous and active-high.
  - While rst is sampled high: state=IDLE, gnt=0, gnt_valid=0, gnt_id=0, timeout=0, last=N-1 (so requester 0 wins first), hold_cnt=0.
  - Reset mid-grant drops gnt on the next edge. No timeout pulse is produced.
- States: IDLE, BUSY. All outputs come from flops. Next-state and pick logic are fully specified on every path (no inferred latches).
- Pick function: first set bit of req scanning last+1, last+2, ... modulo N.
- IDLE:
  - If req != 0 at edge t, then at t+1: gnt=onehot(pick), gnt_id=pick, gnt_valid=1, hold_cnt=0, state=BUSY.
  - Request-to-grant latency is 1 cycle.
- BUSY: hold_cnt increments each cycle (saturating at MAX_HOLD). Release conditions are evaluated each edge, in this priority order:
  1. done=1. Release. last=gnt_id.
  2. req[gnt_id]=0 (withdrawn). Release. last=gnt_id.
  3. hold_cnt==MAX_HOLD-1. Release. last=gnt_id. timeout=1 for exactly one cycle.
- Release effect: the next cycle has gnt=0, gnt_valid=0, gnt_id=0, state=IDLE. There is always at least one idle cycle between grants, which guarantees no grant overlap.
- done while in IDLE is ignored.
- done and timeout in the same cycle: done wins, and no timeout pulse is produced.
- Grant duration is at most MAX_HOLD cycles.
- Changes to other requesters' req bits during BUSY have no effect until IDLE.
- Fairness: a continuously requesting line is granted within N-1 other grants.
- Wrap-around: the scan from last=N-1 starts at index 0.
- Invariants:
  - gnt is zero or one-hot.
  - gnt_valid == |gnt.
  - gnt_id matches gnt when valid.

Decomposition:
- Package rr_arb_pkg:
  - state enum (IDLE, BUSY), 1-bit logic.
  - MAX_N=16 constant.
  - function onehot(idx, N).
- Sub-module rr_pick: purely combinational.
  - Inputs: req[N], last[IDW].
  - Outputs: any, idx[IDW].
  - Implemented as a rotate plus priority encoder, with the case-decoded fallback to idx=0, any=0.
- The top holds the FSM, hold counter, last pointer and output flops.

Test Plan:
1. Reset, then req=4'b0001 at cycle 2 -> gnt=0001, gnt_id=0 at cycle 3. done at cycle 5 -> gnt=0 at cycle 6.
2. req=4'b1111 held, done pulsed each grant -> grant order 0,1,2,3,0 with one idle cycle between grants. gnt is never multi-hot.
3. req=4'b0100 held, done never -> gnt=0100 for exactly 15 cycles. timeout=1 on the first idle cycle. The next grant goes to 2 again, since it is the only requester.
4. Grant to 1, then req[1] drops one cycle later -> gnt=0 the following cycle. last=1, so the next pick with req=4'b0011 is 0.
5. done and hold expiry coincide (done at cycle 15 of the grant) -> release with timeout=0.
6. rst asserted while BUSY -> gnt=0, gnt_valid=0 at the next edge. After reset, req=4'b1000 gives gnt_id=3. req=4'b1001 gives gnt_id=0 (last=N-1).
